hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. Observes the instruction in ID, the instruction in EX and the EX branch resolution. Produces the write-enable, flush and bubble controls for the PC register, the IF/ID pipeline register and the ID/EX pipeline register. Also owns the busy timer for the multi-cycle MULT/DIV unit.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/md_busy_timer.sv | 55 +++++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MULT/DIV timer state encoding, register-zero
// constant and default core parameters.
package pipe_pkg;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned REG_ZERO        = 32'd0;
  localparam int unsigned MDU_LAT_DEFAULT = 32'd32;
  localparam int unsigned REG_AW_DEFAULT  = 32'd5;

  // True when an instruction that really reads src depends on dst.
  function automatic logic src_hit(input logic use_src, input logic [31:0] src,
                                   input logic [31:0] dst);
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX observations in, pipeline controls and perf counters out.
interface hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_md_start;
  logic              id_md_read;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              pc_wr_en;
  logic              ifid_wr_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              md_busy;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_read,
           ex_mem_read, ex_rd, ex_branch_taken,
    input  pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, md_busy,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_read,
           ex_mem_read, ex_rd, ex_branch_taken,
    output pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, md_busy,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/md_busy_timer.sv
// MULT/DIV busy timer: accepts a start in IDLE, then stays BUSY for MDU_LAT-1 cycles.
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int unsigned    CNT_W    = $clog2(MDU_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  // Timer FSM; in BUSY the counter is always >= 1, so it stops at 0 and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_LOAD;
          end else begin
            state_q <= MD_IDLE;
            cnt_q   <= cnt_q;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= MD_IDLE;
          end else begin
            state_q <= MD_BUSY;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use and MULT/DIV stalls.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
  parameter int unsigned REG_AW  = REG_AW_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  logic lu_s;
  logic md_s;
  logic busy_s;
  logic md_start_s;
  logic pc_wr_en_s;
  logic ifid_wr_en_s;
  logic ifid_flush_s;
  logic idex_bubble_s;

  assign lu_s = hz.ex_mem_read & (hz.ex_rd != REG_AW'(REG_ZERO)) &
                (src_hit(hz.id_use_rs, 32'(hz.id_rs), 32'(hz.ex_rd)) |
                 src_hit(hz.id_use_rt, 32'(hz.id_rt), 32'(hz.ex_rd)));

  assign md_s = busy_s & (hz.id_md_start | hz.id_md_read);

  // A start squashed by a flush or held by load-use never reaches EX; the timer ignores it while BUSY.
  assign md_start_s = hz.id_md_start & ~hz.ex_branch_taken & ~lu_s;

  md_busy_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_md_busy_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start_s),
    .busy  (busy_s)
  );

  // Flush outranks every stall; stalls freeze PC and IF/ID and bubble ID/EX.
  always_comb begin
    pc_wr_en_s    = 1'b1;
    ifid_wr_en_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    if (hz.ex_branch_taken) begin
      pc_wr_en_s    = 1'b1;
      ifid_wr_en_s  = 1'b1;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (lu_s | md_s) begin
      pc_wr_en_s    = 1'b0;
      ifid_wr_en_s  = 1'b0;
      ifid_flush_s  = 1'b0;
      idex_bubble_s = 1'b1;
    end else begin
      pc_wr_en_s    = 1'b1;
      ifid_wr_en_s  = 1'b1;
      ifid_flush_s  = 1'b0;
      idex_bubble_s = 1'b0;
    end
  end

  assign hz.pc_wr_en    = pc_wr_en_s;
  assign hz.ifid_wr_en  = ifid_wr_en_s;
  assign hz.ifid_flush  = ifid_flush_s;
  assign hz.idex_bubble = idex_bubble_s;
  assign hz.md_busy     = busy_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Next-state for the wrapping perf counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.ex_branch_taken) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (lu_s | md_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Perf counter flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.perf_stall_cnt = stall_cnt_q;
  assign hz.perf_flush_cnt = flush_cnt_q;
`else
  assign hz.perf_stall_cnt = 32'd0;
  assign hz.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-numbered reference model.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       urs;
    logic       urt;
    logic       mds;
    logic       mdr;
    logic       mr;
    logic       br;
  } stim_t;

  typedef struct {
    logic        pc;
    logic        ifid;
    logic        flush;
    logic        bubble;
    logic        busy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) hif ();

  hazard_ctrl #(.MDU_LAT(LAT), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: the MULT/DIV is busy in every cycle index below busy_end.
  int          cyc      = 0;
  int          busy_end = 0;
  logic [31:0] m_stall  = 32'd0;
  logic [31:0] m_flush  = 32'd0;

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic chk(input string tag, input string field, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h exp=%0h t=%0t", tag, field, got, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input stim_t s, input string tag);
    exp_t e;
    bit busy, lu, md;
    @(posedge clk);
    #1;
    rst_n               = rn;
    hif.id_rs           = s.rs;
    hif.id_rt           = s.rt;
    hif.id_use_rs       = s.urs;
    hif.id_use_rt       = s.urt;
    hif.id_md_start     = s.mds;
    hif.id_md_read      = s.mdr;
    hif.ex_mem_read     = s.mr;
    hif.ex_rd           = s.rd;
    hif.ex_branch_taken = s.br;
    if (!rn) begin
      busy_end = 0;
      m_stall  = 32'd0;
      m_flush  = 32'd0;
    end
    busy = rn && (cyc < busy_end);
    lu   = s.mr && (s.rd != 5'd0) && ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
    md   = busy && (s.mds || s.mdr);
    e.tag    = tag;
    e.busy   = busy;
    e.flush  = s.br;
    e.bubble = s.br || lu || md;
    e.pc     = s.br || !(lu || md);
    e.ifid   = e.pc;
`ifdef HAZARD_PERF_EN
    e.stall_cnt = m_stall;
    e.flush_cnt = m_flush;
`else
    e.stall_cnt = 32'd0;
    e.flush_cnt = 32'd0;
`endif
    sb.push_back(e);
    if (rn) begin
      if (s.br) m_flush = m_flush + 32'd1;
      else if (lu || md) m_stall = m_stall + 32'd1;
      if (s.mds && !s.br && !lu && !busy) busy_end = cyc + int'(LAT);
    end
    cyc++;
  endtask

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "pc_wr_en",    32'(hif.pc_wr_en),    32'(e.pc));
      chk(e.tag, "ifid_wr_en",  32'(hif.ifid_wr_en),  32'(e.ifid));
      chk(e.tag, "ifid_flush",  32'(hif.ifid_flush),  32'(e.flush));
      chk(e.tag, "idex_bubble", 32'(hif.idex_bubble), 32'(e.bubble));
      chk(e.tag, "md_busy",     32'(hif.md_busy),     32'(e.busy));
      chk(e.tag, "stall_cnt",   hif.perf_stall_cnt,   e.stall_cnt);
      chk(e.tag, "flush_cnt",   hif.perf_flush_cnt,   e.flush_cnt);
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    s = nop();
    step(1'b0, s, "reset0");
    step(1'b0, s, "reset1");
    step(1'b1, s, "idle");

    // Load-use on rs, then the load moves on.
    s = nop(); s.rs = 5'd8; s.urs = 1'b1; s.mr = 1'b1; s.rd = 5'd8;
    step(1'b1, s, "lu_rs");
    s.mr = 1'b0;
    step(1'b1, s, "lu_gone");
    s = nop(); s.rs = 5'd0; s.urs = 1'b1; s.mr = 1'b1; s.rd = 5'd0;
    step(1'b1, s, "lu_r0");
    s = nop(); s.rt = 5'd3; s.urt = 1'b1; s.mr = 1'b1; s.rd = 5'd3;
    step(1'b1, s, "lu_rt");
    s = nop(); s.rs = 5'd8; s.urs = 1'b0; s.mr = 1'b1; s.rd = 5'd8;
    step(1'b1, s, "lu_unused");

    // Branch beats a load-use match.
    s = nop(); s.rs = 5'd8; s.urs = 1'b1; s.mr = 1'b1; s.rd = 5'd8; s.br = 1'b1;
    step(1'b1, s, "br_vs_lu");

    // MULT accepted, dependent MFHI stalls LAT-1 cycles then proceeds.
    s = nop(); s.mds = 1'b1;
    step(1'b1, s, "mult_acc");
    s = nop(); s.mdr = 1'b1;
    for (int i = 0; i < int'(LAT); i++) step(1'b1, s, "mfhi_wait");

    // Back-to-back MULT waits, then reloads the timer.
    s = nop(); s.mds = 1'b1;
    for (int i = 0; i <= int'(LAT); i++) step(1'b1, s, "mult_b2b");
    s = nop(); s.mdr = 1'b1;
    for (int i = 0; i < int'(LAT); i++) step(1'b1, s, "mfhi_b2b");

    // Squashed start.
    s = nop(); s.mds = 1'b1; s.br = 1'b1;
    step(1'b1, s, "mult_squash");
    s = nop(); s.mdr = 1'b1;
    step(1'b1, s, "after_squash");

    // Reset in the middle of BUSY.
    s = nop(); s.mds = 1'b1;
    step(1'b1, s, "mult_pre_rst");
    s = nop();
    step(1'b1, s, "busy_pre_rst");
    s = nop(); s.mdr = 1'b1;
    step(1'b0, s, "rst_mid_busy");
    step(1'b1, s, "mfhi_post_rst");

    // Random traffic with small register ranges to hit matches often.
    for (int i = 0; i < 600; i++) begin
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.urs = 1'($urandom_range(0, 1));
      s.urt = 1'($urandom_range(0, 1));
      s.mr  = 1'($urandom_range(0, 1));
      s.mds = ($urandom_range(0, 5) == 0);
      s.mdr = ($urandom_range(0, 3) == 0);
      s.br  = ($urandom_range(0, 6) == 0);
      step(($urandom_range(0, 79) != 0), s, "rand");
    end

    s = nop();
    step(1'b1, s, "tail");
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
